// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_unit_pkg;

   localparam int INSTR_W = 32;
   localparam int ENTRY_W = 2 * INSTR_W;
   localparam logic [31:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// Show-ahead synchronous FIFO with flush; full/empty told apart by an extra pointer bit.
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head_data,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A simultaneous pop frees the slot, so a full queue may still accept a push.
   assign do_push = push && (!full || do_pop);
   assign count   = wr_ptr_reg - rd_ptr_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr_reg[AW-1:0]] <= push_data;
   end

   assign head_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// PC register and fetch sequencer: issues word fetches and queues returned instructions for decode.
// Optional build macro FETCH_MISALIGN_CHK_EN adds fetch_misalign_o and blocks fetch after a misaligned redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rstn,
   output logic [31:0]        pc_o,
   input  logic               redirect_i,
   input  logic [31:0]        redirect_pc_i,
   output logic               imem_req_o,
   output logic [31:0]        imem_addr_o,
   input  logic               imem_gnt_i,
   input  logic               imem_rvalid_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
`ifdef FETCH_MISALIGN_CHK_EN
   output logic               fetch_misalign_o,
`endif
   output logic               if_valid_o,
   output logic [INSTR_W-1:0] if_instr_o,
   output logic [31:0]        if_pc_o,
   input  logic               if_ready_i
);
   localparam int CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_t       state_reg, state_next;
   logic [31:0]        pc_reg, pc_next;
   logic [31:0]        req_pc_reg, req_pc_next;
   logic               kill_reg, kill_next;
   logic               blocked;
   logic [31:0]        redirect_target;

   logic               granted;
   logic               resp;
   logic               push;
   logic               pop;
   logic               q_empty;
   logic [CW-1:0]      q_count;
   logic [CW-1:0]      count_after;
   logic               can_req;
   fetch_entry_t       push_entry;
   fetch_entry_t       head_entry;
   logic [ENTRY_W-1:0] head_data;

`ifdef FETCH_MISALIGN_CHK_EN
   logic misalign_reg, misalign_next;

   assign redirect_target  = redirect_pc_i;
   assign misalign_next    = redirect_i ? (redirect_pc_i[1:0] != 2'b00) : misalign_reg;
   assign blocked          = misalign_next;
   assign fetch_misalign_o = misalign_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) misalign_reg <= 1'b0;
      else       misalign_reg <= misalign_next;
   end
`else
   assign redirect_target = redirect_pc_i & ~32'h0000_0003;
   assign blocked         = 1'b0;
`endif

   assign granted = (state_reg == S_REQ) && imem_gnt_i;
   // Responses are only meaningful while waiting; one in the grant cycle is ignored.
   assign resp    = (state_reg == S_WAIT) && imem_rvalid_i;
   assign push    = resp && !kill_reg && !redirect_i;
   assign pop     = if_valid_o && if_ready_i;

   // Occupancy as it will be after this edge; the request about to be issued needs a free slot.
   always_comb begin
      if (redirect_i) count_after = '0;
      else            count_after = q_count + CW'(push) - CW'(pop);
      can_req = (count_after < CW'(BUF_DEPTH)) && !blocked;
   end

   always_comb begin
      pc_next     = pc_reg;
      req_pc_next = req_pc_reg;
      kill_next   = kill_reg;
      if (granted) req_pc_next = pc_reg;
      if (redirect_i)   pc_next = redirect_target;
      else if (granted) pc_next = pc_reg + PC_INC;
      if (resp) kill_next = 1'b0;
      if (redirect_i && (granted || ((state_reg == S_WAIT) && !imem_rvalid_i)))
         kill_next = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_reg     <= RESET_PC;
         req_pc_reg <= RESET_PC;
         kill_reg   <= 1'b0;
      end else begin
         pc_reg     <= pc_next;
         req_pc_reg <= req_pc_next;
         kill_reg   <= kill_next;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (can_req) state_next = S_REQ;
         S_REQ: begin
            // An ungranted request is dropped for a cycle before the new address goes out.
            if (imem_gnt_i)      state_next = S_WAIT;
            else if (redirect_i) state_next = S_IDLE;
         end
         S_WAIT: if (imem_rvalid_i) state_next = can_req ? S_REQ : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req_o  = (state_reg == S_REQ);
      imem_addr_o = pc_reg;
      pc_o        = pc_reg;
   end

   assign push_entry = '{pc: req_pc_reg, instr: imem_rdata_i};

   fetch_queue #(
      .DEPTH(BUF_DEPTH),
      .WIDTH(ENTRY_W)
   ) u_queue (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (redirect_i),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head_data),
      .empty     (q_empty),
      .count     (q_count)
   );

   assign head_entry = fetch_entry_t'(head_data);
   assign if_valid_o = !q_empty;
   assign if_pc_o    = head_entry.pc;
   assign if_instr_o = head_entry.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory responder plus pop monitor against hand-built expectations.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] pc_o;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        if_valid_o;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_o;
   logic        if_ready_i = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
   logic        fetch_misalign_o;
`endif

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .pc_o             (pc_o),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_gnt_i       (imem_gnt_i),
      .imem_rvalid_i    (imem_rvalid_i),
      .imem_rdata_i     (imem_rdata_i),
`ifdef FETCH_MISALIGN_CHK_EN
      .fetch_misalign_o (fetch_misalign_o),
`endif
      .if_valid_o       (if_valid_o),
      .if_instr_o       (if_instr_o),
      .if_pc_o          (if_pc_o),
      .if_ready_i       (if_ready_i)
   );

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_pop[$];
   logic [31:0] exp_gnt[$];
   int          gnt_budget = 0;
   int          gnt_count = 0;
   logic        hold = 1'b0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Memory: grant in the request cycle, respond the following cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!rstn) begin
            imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; pend = 1'b0;
         end else begin
            imem_rvalid_i = pend;
            imem_rdata_i  = pend ? {16'hC0DE, pend_addr[15:0]} : 32'h0;
            pend = 1'b0;
            if (imem_req_o && !hold && gnt_budget > 0) begin
               imem_gnt_i = 1'b1;
               gnt_budget--;
               gnt_count++;
               pend = 1'b1;
               pend_addr = imem_addr_o;
               $display("grant addr=%h", imem_addr_o);
               if (exp_gnt.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected grant: got %h, expected none", imem_addr_o);
               end else begin
                  check("grant addr", imem_addr_o, exp_gnt.pop_front());
               end
            end else begin
               imem_gnt_i = 1'b0;
            end
         end
      end
   end

   // Monitor: every accepted head entry is compared with the scoreboard.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (rstn && if_valid_o && if_ready_i) begin
            $display("pop pc=%h instr=%h", if_pc_o, if_instr_o);
            if (exp_pop.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected pop: got pc %h, expected none", if_pc_o);
            end else begin
               e = exp_pop.pop_front();
               check("pop pc", if_pc_o, e[63:32]);
               check("pop instr", if_instr_o, e[31:0]);
            end
         end
      end
   end

   task automatic add_pop(input logic [31:0] pc, input logic [31:0] instr);
      exp_pop.push_back({pc, instr});
   endtask

   task automatic add_gnt(input logic [31:0] a);
      exp_gnt.push_back(a);
   endtask

   // Reset, check reset outputs, release just after a rising edge.
   task automatic do_reset(input int budget, input logic ready);
      rstn = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; hold = 1'b0;
      exp_pop.delete(); exp_gnt.delete();
      gnt_budget = budget; gnt_count = 0; if_ready_i = ready;
      repeat (2) @(posedge clk);
      #1;
      check("reset pc_o", pc_o, 32'h0);
      check("reset req", {31'b0, imem_req_o}, 32'h0);
      check("reset if_valid", {31'b0, if_valid_o}, 32'h0);
      check("reset if_instr", if_instr_o, 32'h0);
      check("reset if_pc", if_pc_o, 32'h0);
      rstn = 1'b1;
   endtask

   task automatic wait_gnts(input int n);
      int t = 0;
      while (gnt_count < n && t < 60) begin @(posedge clk); #1; t++; end
      check("grant count reached", 32'(gnt_count), 32'(n));
   endtask

   task automatic wait_req();
      int t = 0;
      while (!imem_req_o && t < 20) begin @(posedge clk); #1; t++; end
      check("request raised", {31'b0, imem_req_o}, 32'h1);
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while ((exp_pop.size() != 0 || exp_gnt.size() != 0) && t < 100) begin
         @(posedge clk); t++;
      end
      repeat (4) @(posedge clk);
      #1;
      check({name, " pops left"}, 32'(exp_pop.size()), 32'h0);
      check({name, " grants left"}, 32'(exp_gnt.size()), 32'h0);
   endtask

   initial begin
      int n;

      // Straight-line fetch with latency check.
      add_gnt(32'h0); add_gnt(32'h4); add_gnt(32'h8); add_gnt(32'hC);
      do_reset(0, 1'b1);
      add_gnt(32'h0); add_gnt(32'h4); add_gnt(32'h8); add_gnt(32'hC);
      add_pop(32'h0, 32'hC0DE_0000); add_pop(32'h4, 32'hC0DE_0004);
      add_pop(32'h8, 32'hC0DE_0008); add_pop(32'hC, 32'hC0DE_000C);
      gnt_budget = 4;
      n = 0;
      while (!if_valid_o && n < 10) begin @(posedge clk); #1; n++; end
      check("first instr latency", 32'(n), 32'd3);
      wait_drain("sequential");

      // Back-pressure fills exactly two entries.
      do_reset(4, 1'b0);
      add_gnt(32'h0); add_gnt(32'h4); add_gnt(32'h8); add_gnt(32'hC);
      add_pop(32'h0, 32'hC0DE_0000); add_pop(32'h4, 32'hC0DE_0004);
      add_pop(32'h8, 32'hC0DE_0008); add_pop(32'hC, 32'hC0DE_000C);
      repeat (10) @(posedge clk);
      #1;
      check("stall req low", {31'b0, imem_req_o}, 32'h0);
      check("stall grants", 32'(gnt_count), 32'd2);
      check("stall head valid", {31'b0, if_valid_o}, 32'h1);
      check("stall head pc", if_pc_o, 32'h0);
      if_ready_i = 1'b1;
      wait_drain("backpressure");

      // Redirect while waiting for address 8.
      do_reset(4, 1'b1);
      add_gnt(32'h0); add_gnt(32'h4); add_gnt(32'h8); add_gnt(32'h100);
      add_pop(32'h0, 32'hC0DE_0000); add_pop(32'h4, 32'hC0DE_0004);
      add_pop(32'h100, 32'hC0DE_0100);
      wait_gnts(3);
      redirect_i = 1'b1; redirect_pc_i = 32'h100;
      @(posedge clk); #1;
      redirect_i = 1'b0;
      check("wait-redirect queue empty", {31'b0, if_valid_o}, 32'h0);
      check("wait-redirect pc", pc_o, 32'h100);
      check("wait-redirect req", {31'b0, imem_req_o}, 32'h1);
      wait_drain("wait redirect");

      // Redirect coinciding with the grant of address C.
      do_reset(5, 1'b1);
      add_gnt(32'h0); add_gnt(32'h4); add_gnt(32'h8); add_gnt(32'hC); add_gnt(32'h200);
      add_pop(32'h0, 32'hC0DE_0000); add_pop(32'h4, 32'hC0DE_0004);
      add_pop(32'h8, 32'hC0DE_0008); add_pop(32'h200, 32'hC0DE_0200);
      wait_gnts(3);
      @(posedge clk); #1;
      redirect_i = 1'b1; redirect_pc_i = 32'h200;
      @(posedge clk); #1;
      redirect_i = 1'b0;
      check("grant-redirect pc", pc_o, 32'h200);
      check("grant-redirect req", {31'b0, imem_req_o}, 32'h0);
      check("grant-redirect queue empty", {31'b0, if_valid_o}, 32'h0);
      wait_drain("grant redirect");

      // Grant withheld: address and request stay put.
      hold = 1'b1;
      do_reset(2, 1'b1);
      hold = 1'b1;
      add_gnt(32'h0); add_gnt(32'h4);
      add_pop(32'h0, 32'hC0DE_0000); add_pop(32'h4, 32'hC0DE_0004);
      wait_req();
      for (int i = 0; i < 5; i++) begin
         check("held req", {31'b0, imem_req_o}, 32'h1);
         check("held addr", imem_addr_o, 32'h0);
         check("held pc", pc_o, 32'h0);
         @(posedge clk); #1;
      end
      hold = 1'b0;
      wait_gnts(1);
      check("pc after grant", pc_o, 32'h4);
      wait_drain("held grant");

      // PC wrap at the top of the address space.
      do_reset(0, 1'b1);
      add_gnt(32'hFFFF_FFFC); add_gnt(32'h0);
      add_pop(32'hFFFF_FFFC, 32'hC0DE_FFFC); add_pop(32'h0, 32'hC0DE_0000);
      wait_req();
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      @(posedge clk); #1;
      redirect_i = 1'b0;
      check("abandon req low", {31'b0, imem_req_o}, 32'h0);
      check("abandon pc", pc_o, 32'hFFFF_FFFC);
      gnt_budget = 2;
      wait_drain("wrap");

`ifdef FETCH_MISALIGN_CHK_EN
      // Misaligned redirect blocks fetch until an aligned one arrives.
      do_reset(0, 1'b1);
      add_gnt(32'h104); add_gnt(32'h108);
      add_pop(32'h104, 32'hC0DE_0104); add_pop(32'h108, 32'hC0DE_0108);
      wait_req();
      redirect_i = 1'b1; redirect_pc_i = 32'h102;
      @(posedge clk); #1;
      redirect_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("misalign flag", {31'b0, fetch_misalign_o}, 32'h1);
         check("misalign req low", {31'b0, imem_req_o}, 32'h0);
         @(posedge clk); #1;
      end
      redirect_i = 1'b1; redirect_pc_i = 32'h104; gnt_budget = 2;
      @(posedge clk); #1;
      redirect_i = 1'b0;
      check("misalign cleared", {31'b0, fetch_misalign_o}, 32'h0);
      check("aligned pc", pc_o, 32'h104);
      wait_drain("misalign");
`else
      // Low address bits are dropped on redirect.
      do_reset(0, 1'b1);
      add_gnt(32'h100);
      add_pop(32'h100, 32'hC0DE_0100);
      wait_req();
      redirect_i = 1'b1; redirect_pc_i = 32'h102;
      @(posedge clk); #1;
      redirect_i = 1'b0;
      check("aligned redirect pc", pc_o, 32'h100);
      gnt_budget = 1;
      wait_drain("align");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
